pong_renderer: RTL and testbench

Game-state and pixel stage directly downstream of the VGA timing generator. Consumes the pixel coordinates and blanking/sync outputs, runs the Pong ball/score state machine once per frame during vertical sync, and produces registered 8-bit RGB for the video DAC. Paddle positions come from the input-handling logic upstream.

---
 rtl/pong_renderer.sv | 196 +++++++++++++++++++
 tb/tb_pong_renderer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_renderer.sv
// Pong game state, updated once per frame on the vs falling edge, plus the registered RGB pixel stage.
// Define PONG_NET_EN to draw the dashed centre net.
module pong_renderer #(
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_W     = 8,
   parameter int PADDLE_H     = 64,
   parameter int PADDLE_L_X   = 16,
   parameter int PADDLE_R_X   = 616,
   parameter int BALL_SPEED   = 2,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30
) (
   input  logic       clk_vga,
   input  logic       rst,
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic       blank_n,
   input  logic       vs,
   input  logic [8:0] paddle_l_y,
   input  logic [8:0] paddle_r_y,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       playing
);
   localparam logic [1:0] S_SERVE = 2'd0;
   localparam logic [1:0] S_PLAY  = 2'd1;
   localparam logic [1:0] S_POINT = 2'd2;

   localparam logic [10:0] BS     = 11'(BALL_SIZE);
   localparam logic [10:0] PW     = 11'(PADDLE_W);
   localparam logic [10:0] PH     = 11'(PADDLE_H);
   localparam logic [10:0] PLX    = 11'(PADDLE_L_X);
   localparam logic [10:0] PRX    = 11'(PADDLE_R_X);
   localparam logic [10:0] SPD    = 11'(BALL_SPEED);
   localparam logic [10:0] L_FACE = PLX + PW;
   localparam logic [10:0] Y_MAX  = 11'd480 - BS;
   localparam logic [10:0] X_MAX  = 11'd640 - BS;
   localparam logic [10:0] CTR_X  = (11'd640 - BS) >> 1;
   localparam logic [10:0] CTR_Y  = (11'd480 - BS) >> 1;
   localparam logic [5:0]  SERVE_LAST = 6'(SERVE_FRAMES - 1);
   localparam logic [5:0]  POINT_LAST = 6'(POINT_FRAMES - 1);

   logic        vs_q, vs_d, tick;
   logic [1:0]  state_q, state_d;
   logic [9:0]  ball_x_q, ball_x_d;
   logic [8:0]  ball_y_q, ball_y_d;
   logic        dx_q, dx_d, dy_q, dy_d;
   logic [5:0]  fcnt_q, fcnt_d;
   logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
   logic [8:0]  pad_l_q, pad_l_d, pad_r_q, pad_r_d;
   logic [23:0] rgb_q, rgb_d;

   logic [10:0] bx, by, pl, pr, nx, ny, x11, y11;
   logic        on_ball, on_pad, on_net;

   assign bx   = {1'b0, ball_x_q};
   assign by   = {2'b0, ball_y_q};
   assign pl   = {2'b0, paddle_l_y};
   assign pr   = {2'b0, paddle_r_y};
   assign x11  = {1'b0, x};
   assign y11  = {2'b0, y};
   assign tick = vs_q & ~vs;

   always_comb begin
      vs_d      = vs;
      state_d   = state_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      fcnt_d    = fcnt_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      pad_l_d   = pad_l_q;
      pad_r_d   = pad_r_q;
      nx        = bx;
      ny        = by;
      if (tick) begin
         pad_l_d = paddle_l_y;
         pad_r_d = paddle_r_y;
         case (state_q)
            S_SERVE: begin
               if (fcnt_q == SERVE_LAST) begin
                  state_d = S_PLAY;
                  fcnt_d  = 6'd0;
               end else begin
                  fcnt_d = fcnt_q + 6'd1;
               end
            end
            S_PLAY: begin
               // Every rule tests the pre-move position; later rules override earlier ones.
               nx = dx_q ? bx + SPD : bx - SPD;
               ny = dy_q ? by + SPD : by - SPD;
               if (!dy_q && by < SPD) begin
                  ny   = 11'd0;
                  dy_d = 1'b1;
               end
               if (dy_q && by + SPD > Y_MAX) begin
                  ny   = Y_MAX;
                  dy_d = 1'b0;
               end
               if (!dx_q && bx >= L_FACE && bx - SPD < L_FACE && by + BS > pl && by < pl + PH) begin
                  nx   = L_FACE;
                  dx_d = 1'b1;
               end
               if (dx_q && bx + BS <= PRX && bx + BS + SPD > PRX && by + BS > pr && by < pr + PH) begin
                  nx   = PRX - BS;
                  dx_d = 1'b0;
               end
               if (!dx_q && bx < SPD) begin
                  nx        = 11'd0;
                  dx_d      = 1'b0;
                  score_r_d = (score_r_q == 4'd9) ? 4'd0 : score_r_q + 4'd1;
                  state_d   = S_POINT;
                  fcnt_d    = 6'd0;
               end
               if (dx_q && bx + BS + SPD > 11'd640) begin
                  nx        = X_MAX;
                  dx_d      = 1'b1;
                  score_l_d = (score_l_q == 4'd9) ? 4'd0 : score_l_q + 4'd1;
                  state_d   = S_POINT;
                  fcnt_d    = 6'd0;
               end
            end
            S_POINT: begin
               // dx still points at the side that conceded, so the serve heads there.
               if (fcnt_q == POINT_LAST) begin
                  state_d = S_SERVE;
                  fcnt_d  = 6'd0;
                  nx      = CTR_X;
                  ny      = CTR_Y;
               end else begin
                  fcnt_d = fcnt_q + 6'd1;
               end
            end
            default: state_d = S_SERVE;
         endcase
      end
      ball_x_d = 10'(nx);
      ball_y_d = 9'(ny);
   end

   always_comb begin
      on_ball = (state_q != S_POINT) && x11 >= bx && x11 < bx + BS && y11 >= by && y11 < by + BS;
      on_pad  = (y11 >= {2'b0, pad_l_q} && y11 < {2'b0, pad_l_q} + PH && x11 >= PLX && x11 < PLX + PW) ||
                (y11 >= {2'b0, pad_r_q} && y11 < {2'b0, pad_r_q} + PH && x11 >= PRX && x11 < PRX + PW);
`ifdef PONG_NET_EN
      on_net  = (x >= 10'd318) && (x <= 10'd321) && !y[4];
`else
      on_net  = 1'b0;
`endif
      rgb_d = 24'h000000;
      if (blank_n) begin
         if (on_ball || on_pad) rgb_d = 24'hFFFFFF;
         else if (on_net)       rgb_d = 24'h808080;
      end
   end

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         vs_q      <= 1'b1;
         state_q   <= S_SERVE;
         ball_x_q  <= 10'(CTR_X);
         ball_y_q  <= 9'(CTR_Y);
         dx_q      <= 1'b1;
         dy_q      <= 1'b1;
         fcnt_q    <= 6'd0;
         score_l_q <= 4'd0;
         score_r_q <= 4'd0;
         pad_l_q   <= 9'd0;
         pad_r_q   <= 9'd0;
         rgb_q     <= 24'h000000;
      end else begin
         vs_q      <= vs_d;
         state_q   <= state_d;
         ball_x_q  <= ball_x_d;
         ball_y_q  <= ball_y_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         fcnt_q    <= fcnt_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         pad_l_q   <= pad_l_d;
         pad_r_q   <= pad_r_d;
         rgb_q     <= rgb_d;
      end
   end

   assign VGA_R   = rgb_q[23:16];
   assign VGA_G   = rgb_q[15:8];
   assign VGA_B   = rgb_q[7:0];
   assign score_l = score_l_q;
   assign score_r = score_r_q;
   assign playing = (state_q == S_PLAY);
endmodule

// File: tb/tb_pong_renderer.sv
// Bench for pong_renderer: frame-level game model checked against the DUT every cycle,
// plus literal expectations along a hand-traced ball trajectory.
module tb_pong_renderer;
   logic       clk_vga = 1'b0;
   logic       rst;
   logic [9:0] x;
   logic [8:0] y;
   logic       blank_n, vs;
   logic [8:0] paddle_l_y, paddle_r_y;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic [3:0] score_l, score_r;
   logic       playing;

   int checks = 0;
   int errors = 0;
   int pmode  = 0;

   pong_renderer dut (
      .clk_vga(clk_vga), .rst(rst), .x(x), .y(y), .blank_n(blank_n), .vs(vs),
      .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .score_l(score_l), .score_r(score_r), .playing(playing)
   );

   always #5 clk_vga = ~clk_vga;

   // st: 0 serve, 1 play, 2 point
   typedef struct {
      int bx; int by; int dx; int dy; int st; int fc; int sl; int sr; int pl; int pr;
   } mst_t;

   function automatic mst_t m_reset();
      mst_t s;
      s.bx = 316; s.by = 236; s.dx = 1; s.dy = 1; s.st = 0; s.fc = 0;
      s.sl = 0; s.sr = 0; s.pl = 0; s.pr = 0;
      return s;
   endfunction

   function automatic mst_t m_step(mst_t s, int lin, int rin);
      mst_t n = s;
      n.pl = lin;
      n.pr = rin;
      if (s.st == 0) begin
         if (s.fc == 59) begin n.st = 1; n.fc = 0; end
         else n.fc = s.fc + 1;
      end else if (s.st == 1) begin
         n.bx = (s.dx == 1) ? s.bx + 2 : s.bx - 2;
         n.by = (s.dy == 1) ? s.by + 2 : s.by - 2;
         if (s.dy == 0 && s.by < 2)   begin n.by = 0;   n.dy = 1; end
         if (s.dy == 1 && s.by > 470) begin n.by = 472; n.dy = 0; end
         if (s.dx == 0 && s.bx >= 24 && s.bx - 2 < 24 && s.by + 8 > lin && s.by < lin + 64) begin
            n.bx = 24; n.dx = 1;
         end
         if (s.dx == 1 && s.bx + 8 <= 616 && s.bx + 10 > 616 && s.by + 8 > rin && s.by < rin + 64) begin
            n.bx = 608; n.dx = 0;
         end
         if (s.dx == 0 && s.bx < 2) begin
            n.bx = 0; n.dx = 0; n.sr = (s.sr + 1) % 10; n.st = 2; n.fc = 0;
         end
         if (s.dx == 1 && s.bx + 10 > 640) begin
            n.bx = 632; n.dx = 1; n.sl = (s.sl + 1) % 10; n.st = 2; n.fc = 0;
         end
      end else begin
         if (s.fc == 29) begin n.st = 0; n.fc = 0; n.bx = 316; n.by = 236; end
         else n.fc = s.fc + 1;
      end
      return n;
   endfunction

   function automatic int m_pix(mst_t s, int px, int py, bit bl);
      bit ball, pad, net;
      ball = s.st != 2 && px >= s.bx && px < s.bx + 8 && py >= s.by && py < s.by + 8;
      pad  = (px >= 16 && px < 24 && py >= s.pl && py < s.pl + 64) ||
             (px >= 616 && px < 624 && py >= s.pr && py < s.pr + 64);
`ifdef PONG_NET_EN
      net  = px >= 318 && px <= 321 && ((py / 16) % 2 == 0);
`else
      net  = 1'b0;
`endif
      if (!bl) return 0;
      if (ball || pad) return 32'hFFFFFF;
      if (net) return 32'h808080;
      return 0;
   endfunction

   mst_t m;
   int   exp_rgb;
   logic m_vs;

   always @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         m       <= m_reset();
         exp_rgb <= 0;
         m_vs    <= 1'b1;
      end else begin
         exp_rgb <= m_pix(m, int'(x), int'(y), blank_n);
         if (m_vs && !vs) m <= m_step(m, int'(paddle_l_y), int'(paddle_r_y));
         m_vs <= vs;
      end
   end

   task automatic chk(input string nm, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, want, $time);
      end
   endtask

   always @(negedge clk_vga) begin
      chk("rgb", int'({VGA_R, VGA_G, VGA_B}), exp_rgb);
      chk("score_l", int'(score_l), m.sl);
      chk("score_r", int'(score_r), m.sr);
      chk("playing", int'(playing), (m.st == 1) ? 1 : 0);
   end

   function automatic int clampi(int v, int lo, int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task automatic cyc();
      @(negedge clk_vga);
      #2;
   endtask

   task automatic drive_px();
      int px, py;
      case ($urandom_range(0, 3))
         0: begin px = m.bx - 2 + int'($urandom_range(0, 11)); py = m.by - 2 + int'($urandom_range(0, 11)); end
         1: begin
            if ($urandom_range(0, 1) == 1) begin px = 614 + int'($urandom_range(0, 11)); py = m.pr - 2 + int'($urandom_range(0, 67)); end
            else begin px = 14 + int'($urandom_range(0, 11)); py = m.pl - 2 + int'($urandom_range(0, 67)); end
         end
         2: begin px = 316 + int'($urandom_range(0, 7)); py = int'($urandom_range(0, 479)); end
         default: begin px = int'($urandom_range(0, 639)); py = int'($urandom_range(0, 479)); end
      endcase
      x = 10'(clampi(px, 0, 639));
      y = 9'(clampi(py, 0, 479));
      blank_n = ($urandom_range(0, 7) != 0);
   endtask

   // One short frame: vs low for one cycle, then three visible cycles.
   task automatic frame();
      cyc();
      if (pmode != 0) paddle_r_y = 9'(clampi(m.by, 0, 416));
      if (pmode == 1) paddle_l_y = 9'(clampi(m.by, 0, 416));
      else if (pmode == 2) paddle_l_y = (m.by >= 240) ? 9'd0 : 9'd400;
      vs = 1'b0;
      drive_px();
      repeat (3) begin
         cyc();
         vs = 1'b1;
         drive_px();
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) frame();
   endtask

   task automatic probe(input string nm, input int px, input int py, input bit bl, input int want);
      cyc();
      vs = 1'b1;
      x = 10'(px);
      y = 9'(py);
      blank_n = bl;
      @(posedge clk_vga);
      #1;
      chk(nm, int'({VGA_R, VGA_G, VGA_B}), want);
   endtask

   localparam int WHITE = 32'hFFFFFF;
`ifdef PONG_NET_EN
   localparam int NET_C = 32'h808080;
`else
   localparam int NET_C = 0;
`endif

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int bounces, n, pre_dx, pre_st;
      rst = 1'b1; vs = 1'b1; x = '0; y = '0; blank_n = 1'b0;
      paddle_l_y = 9'd200; paddle_r_y = 9'd200;
      repeat (3) @(negedge clk_vga);
      #1;
      chk("rst_rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
      chk("rst_score_l", int'(score_l), 0);
      chk("rst_score_r", int'(score_r), 0);
      chk("rst_playing", int'(playing), 0);
      cyc();
      rst = 1'b0;

      probe("serve_ball", 316, 236, 1'b1, WHITE);
      probe("serve_ball_edge", 324, 236, 1'b1, 0);
      ticks(59);
      chk("serve_59", int'(playing), 0);
      ticks(1);
      chk("serve_60", int'(playing), 1);
      ticks(1);
      chk("model_bx_61", m.bx, 318);
      chk("model_by_61", m.by, 238);
      probe("ball_61", 318, 238, 1'b1, WHITE);
      probe("ball_61_left", 317, 238, 1'b1, 0);
      probe("ball_61_blank", 318, 238, 1'b0, 0);

      // Round 1: right paddle parked at 200 never meets the ball.
      ticks(118);
      chk("bottom_by", m.by, 472);
      chk("bottom_dy", m.dy, 0);
      probe("bottom_px", 554, 472, 1'b1, WHITE);
      probe("bottom_above", 554, 471, 1'b1, 0);
      ticks(39);
      chk("score_l_218", int'(score_l), 0);
      ticks(1);
      chk("score_l_219", int'(score_l), 1);
      chk("point_playing", int'(playing), 0);
      probe("point_hidden", 632, 392, 1'b1, 0);
      ticks(29);
      probe("point_29", 316, 236, 1'b1, 0);
      ticks(1);
      probe("serve_again", 316, 236, 1'b1, WHITE);
      ticks(60);
      chk("play_309", int'(playing), 1);

      // Round 2 starts moving up and rests one extra tick on the top wall.
      ticks(119);
      chk("top_by", m.by, 0);
      chk("top_dy", m.dy, 1);
      probe("top_px", 554, 0, 1'b1, WHITE);
      ticks(2031);
      chk("score_l_9", int'(score_l), 9);
      ticks(1);
      chk("score_l_wrap", int'(score_l), 0);
      chk("score_r_still", int'(score_r), 0);

      // Rally with both paddles tracking the ball.
      pmode = 1;
      bounces = 0;
      n = 0;
      while (bounces < 2 && n < 4000) begin
         pre_dx = m.dx;
         pre_st = m.st;
         frame();
         n++;
         if (pre_st == 1 && pre_dx == 0 && m.dx == 1 && m.st == 1) begin
            bounces++;
            chk("lbounce_x", m.bx, 24);
            chk("lbounce_score", int'(score_r), 0);
            probe("lbounce_px", 25, m.by + 3, 1'b1, WHITE);
            probe("lbounce_past", 32, m.by + 3, 1'b1, 0);
         end
      end
      if (bounces < 2) chk("lbounce_timeout", bounces, 2);

      // Left paddle dodges: left player concedes.
      pmode = 2;
      n = 0;
      while (m.sr == 0 && n < 4000) begin
         frame();
         n++;
      end
      chk("lmiss_score_r", int'(score_r), 1);
      chk("lmiss_score_l", int'(score_l), 0);
      chk("lmiss_playing", int'(playing), 0);
      ticks(29);
      probe("lmiss_point", 316, 236, 1'b1, 0);
      ticks(1);
      probe("lmiss_serve", 316, 236, 1'b1, WHITE);
      ticks(60);
      chk("lmiss_play", int'(playing), 1);
      ticks(1);
      chk("serve_left_bx", m.bx, 314);
      probe("serve_left_px", 314, m.by, 1'b1, WHITE);
      probe("serve_left_out", 313, m.by, 1'b1, 0);

      ticks(5);
      cyc();
      x = 10'(m.bx); y = 9'(m.by); blank_n = 1'b1; vs = 1'b1;
      @(posedge clk_vga);
      #1;
      chk("pre_rst_ball", int'({VGA_R, VGA_G, VGA_B}), WHITE);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
      chk("async_score_r", int'(score_r), 0);
      chk("async_playing", int'(playing), 0);
      cyc();
      cyc();
      rst = 1'b0;
      ticks(59);
      chk("rst_serve_59", int'(playing), 0);
      ticks(1);
      chk("rst_serve_60", int'(playing), 1);
      ticks(1);
      probe("rst_ball_61", 318, 238, 1'b1, WHITE);

      probe("net_on", 320, 5, 1'b1, NET_C);
      probe("net_gap", 320, 16, 1'b1, 0);
      probe("net_blank", 320, 5, 1'b0, 0);

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
